// File: rtl/spike_rate_counter.sv
// Spike onset counter over a fixed clock window with a valid/ack result port.
// Ports: clk, rst_n, ena, spike_in, count_ack -> count_out, count_valid, saturated, overrun.
module spike_rate_counter #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
    parameter int unsigned CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_in,
    input  logic             count_ack,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             saturated,
    output logic             overrun
);

    localparam logic [23:0]      LAST = MAX_COUNT - 24'd1;
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic {
        IDLE,
        FULL
    } state_e;

    state_e           state_q, state_d;
    logic             spike_q;
    logic [23:0]      timer_q, timer_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             sat_w_q, sat_w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             ovr_q, ovr_d;

    logic             ev;
    logic             win_end;
    logic             at_max;
    logic             clip;
    logic [CNT_W-1:0] acc_next;

    always_comb begin
        ev       = spike_in & ~spike_q & ena;
        win_end  = ena & (timer_q == LAST);
        at_max   = (acc_q == CMAX);
        clip     = ev & at_max;
        acc_next = at_max ? acc_q : acc_q + CNT_W'(ev);
    end

    // Window datapath: everything freezes while ena is low.
    always_comb begin
        timer_d = timer_q;
        acc_d   = acc_q;
        sat_w_d = sat_w_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (ena) begin
            if (win_end) begin
                // A spike on the last cycle still belongs to this window.
                timer_d = 24'd0;
                acc_d   = '0;
                sat_w_d = 1'b0;
                cnt_d   = acc_next;
                sat_d   = sat_w_q | clip;
            end else begin
                timer_d = timer_q + 24'd1;
                acc_d   = acc_next;
                sat_w_d = sat_w_q | clip;
            end
        end
    end

    // Result handshake FSM.
    always_comb begin
        state_d = state_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (win_end) state_d = FULL;
            end
            FULL: begin
                if (count_ack) begin
                    ovr_d = 1'b0;
                    if (!win_end) state_d = IDLE;
                end else if (win_end) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            spike_q <= 1'b0;
            timer_q <= 24'd0;
            acc_q   <= '0;
            sat_w_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            spike_q <= spike_in;
            timer_q <= timer_d;
            acc_q   <= acc_d;
            sat_w_q <= sat_w_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
        end
    end

    assign count_out   = cnt_q;
    assign count_valid = (state_q == FULL);
    assign saturated   = sat_q;
    assign overrun     = ovr_q;

endmodule
